branch_flag_unit: RTL

Consumer side of the ALU zero/flag path in the pipelined core. Holds the architectural NZCV flag register, written by flag-setting instructions in EX. Resolves branches in ID: B, B.cond, CBZ and CBNZ, using the Z flag from the 64-bit zero detector and the CBZ register-zero indication. Registers the taken decision for the fetch stage, with forwarding of a same-cycle flag update from EX.

---
 rtl/branch_flag_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/branch_flag_unit.sv
// branch_flag_unit: architectural NZCV flag register and ID-stage branch
// resolver (B, B.cond, CBZ, CBNZ) with EX-to-ID flag forwarding.
module branch_flag_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic        ex_set_flags,
    input  logic [3:0]  ex_flags,
    input  logic        id_valid,
    input  logic [2:0]  id_br_type,
    input  logic [3:0]  id_cond,
    input  logic        id_rt_zero,
    output logic [3:0]  flags,
    output logic        br_valid,
    output logic        br_taken,
    output logic [15:0] br_count
);

    localparam logic [2:0] BR_B    = 3'b001;
    localparam logic [2:0] BR_COND = 3'b010;
    localparam logic [2:0] BR_CBZ  = 3'b011;
    localparam logic [2:0] BR_CBNZ = 3'b100;

    logic       fwd;
    logic       upd;
    logic [3:0] eff;
    logic       n;
    logic       z;
    logic       c;
    logic       v;
    logic       cond_ok;
    logic       is_br;
    logic       take;

    assign fwd = ex_valid & ex_set_flags;
    assign upd = fwd & ~stall;

    // Forward the EX result so SUBS followed by B.cond needs no bubble.
    always_comb begin
        eff = fwd ? ex_flags : flags;
        n   = eff[3];
        z   = eff[2];
        c   = eff[1];
        v   = eff[0];
    end

    // Condition code evaluation on the effective flags.
    always_comb begin
        cond_ok = 1'b0;
        unique case (id_cond)
            4'b0000: cond_ok = z;
            4'b0001: cond_ok = ~z;
            4'b0010: cond_ok = c;
            4'b0011: cond_ok = ~c;
            4'b0100: cond_ok = n;
            4'b0101: cond_ok = ~n;
            4'b0110: cond_ok = v;
            4'b0111: cond_ok = ~v;
            4'b1000: cond_ok = c & ~z;
            4'b1001: cond_ok = ~(c & ~z);
            4'b1010: cond_ok = (n == v);
            4'b1011: cond_ok = (n != v);
            4'b1100: cond_ok = ~z & (n == v);
            4'b1101: cond_ok = z | (n != v);
            4'b1110: cond_ok = 1'b1;
            4'b1111: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // Branch classification; CBZ/CBNZ look only at the Rt zero indication.
    always_comb begin
        is_br = 1'b0;
        take  = 1'b0;
        case (id_br_type)
            BR_B: begin
                is_br = id_valid;
                take  = 1'b1;
            end
            BR_COND: begin
                is_br = id_valid;
                take  = cond_ok;
            end
            BR_CBZ: begin
                is_br = id_valid;
                take  = id_rt_zero;
            end
            BR_CBNZ: begin
                is_br = id_valid;
                take  = ~id_rt_zero;
            end
            default: begin
                is_br = 1'b0;
                take  = 1'b0;
            end
        endcase
    end

    // Flag register: an older EX update commits even when ID is flushed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (upd) begin
            flags <= ex_flags;
        end
    end

    // Registered branch decision and taken-branch counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_valid <= 1'b0;
            br_taken <= 1'b0;
            br_count <= 16'h0000;
        end else if (flush) begin
            br_valid <= 1'b0;
            br_taken <= 1'b0;
        end else if (!stall) begin
            br_valid <= is_br;
            br_taken <= is_br & take;
            if (is_br & take) begin
                br_count <= br_count + 16'h0001;
            end
        end
    end

endmodule
